// File: rtl/cardinal_output_arbiter_pkg.sv
// Shared router constants: port indices, flit width, pointer width.
// Also used by routing logic and the testbench.
package cardinal_output_arbiter_pkg;

  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_PE   = 4;
  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 64;
  localparam int PTR_W     = 3;

  function automatic int rr_next(
    input int k,
    input int n
  );
    return (k == n - 1) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/cardinal_output_arbiter_if.sv
// Request side (req/req_data/gnt) and downstream link
// (so/dout/ro) of one output-port VC controller.
interface cardinal_output_arbiter_if
  import cardinal_output_arbiter_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int DW     = FLIT_W
);

  logic [NUM_IN-1:0]    req;
  logic [NUM_IN*DW-1:0] req_data;
  logic [NUM_IN-1:0]    gnt;
  logic                 so;
  logic [DW-1:0]        dout;
  logic                 ro;

  modport master (
    input  req,
    input  req_data,
    output gnt,
    output so,
    output dout,
    input  ro
  );

  modport slave (
    output req,
    output req_data,
    input  gnt,
    input  so,
    input  dout,
    output ro
  );

endinterface

// File: rtl/cardinal_output_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit
// searching circularly upward from ptr, one-hot out.
module cardinal_output_arbiter_rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt
);

  // walk offsets 0..N-1 from ptr; first hit wins
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && en && !found && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cardinal_output_arbiter.sv
// Per-output, per-VC controller: round-robin grant in the
// internal phase into a 1-deep buffer, so/ro drain in external.
module cardinal_output_arbiter #(
  parameter int NUM_IN =
    cardinal_output_arbiter_pkg::NUM_PORTS,
  parameter int DW =
    cardinal_output_arbiter_pkg::FLIT_W,
  parameter int PTR_W =
    cardinal_output_arbiter_pkg::PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phase_internal,
  input  logic             phase_external,
  cardinal_output_arbiter_if.master bus,
  output logic             full,
  output logic [PTR_W-1:0] rr_ptr
);

  import cardinal_output_arbiter_pkg::*;

  logic             grant_en;
  logic [NUM_IN-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [DW-1:0]    gnt_data;
  logic [DW-1:0]    buf_data;
  logic             fill;
  logic             drain;

  // reset gates the grant so gnt drops without a clock edge
  assign grant_en = reset & phase_internal
                  & ~phase_external & ~full
                  & (|bus.req);

  cardinal_output_arbiter_rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (bus.req),
    .ptr (rr_ptr),
    .en  (grant_en),
    .gnt (gnt)
  );

  // encode the one-hot grant and mux the winning flit
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign fill     = |gnt;
  assign bus.so   = full & phase_external;
  assign bus.dout = buf_data;
  assign bus.gnt  = gnt;
  assign drain    = bus.so & bus.ro;

  // buffer, full flag and priority pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      buf_data <= '0;
      rr_ptr   <= '0;
    end else if (fill) begin
      full     <= 1'b1;
      buf_data <= gnt_data;
      rr_ptr   <= PTR_W'(rr_next(int'(gnt_idx), NUM_IN));
    end else if (drain) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cardinal_output_arbiter.sv
// Table-driven bench for cardinal_output_arbiter plus a
// hand-written asynchronous-reset-mid-stall sequence.
module tb_cardinal_output_arbiter;

  import cardinal_output_arbiter_pkg::*;

  typedef struct {
    logic        pi;
    logic        pe;
    logic [4:0]  req;
    logic        ro;
    logic [4:0]  gnt;
    logic        so;
    logic [63:0] dout;
    logic        full;
    logic [2:0]  ptr;
  } vec_t;

  vec_t tbl[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pi = 1'b0;
  logic       pe = 1'b0;
  logic       full;
  logic [2:0] rr_ptr;

  logic [63:0] dat [5];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cardinal_output_arbiter_if bus ();

  cardinal_output_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .phase_internal (pi),
    .phase_external (pe),
    .bus            (bus),
    .full           (full),
    .rr_ptr         (rr_ptr)
  );

  task automatic add(
    input logic        a_pi,
    input logic        a_pe,
    input logic [4:0]  a_req,
    input logic        a_ro,
    input logic [4:0]  a_gnt,
    input logic        a_so,
    input logic [63:0] a_dout,
    input logic        a_full,
    input logic [2:0]  a_ptr
  );
    vec_t v;
    v.pi   = a_pi;
    v.pe   = a_pe;
    v.req  = a_req;
    v.ro   = a_ro;
    v.gnt  = a_gnt;
    v.so   = a_so;
    v.dout = a_dout;
    v.full = a_full;
    v.ptr  = a_ptr;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    pi      = v.pi;
    pe      = v.pe;
    bus.req = v.req;
    bus.ro  = v.ro;
  endtask

  task automatic chk(input string tag, input vec_t v);
    n_vec++;
    if (bus.gnt !== v.gnt) begin
      n_bad++;
      $display("FAIL %s gnt got %b want %b",
               tag, bus.gnt, v.gnt);
    end
    if (bus.so !== v.so) begin
      n_bad++;
      $display("FAIL %s so got %b want %b",
               tag, bus.so, v.so);
    end
    if (bus.dout !== v.dout) begin
      n_bad++;
      $display("FAIL %s do got %h want %h",
               tag, bus.dout, v.dout);
    end
    if (full !== v.full) begin
      n_bad++;
      $display("FAIL %s full got %b want %b",
               tag, full, v.full);
    end
    if (rr_ptr !== v.ptr) begin
      n_bad++;
      $display("FAIL %s rr_ptr got %0d want %0d",
               tag, rr_ptr, v.ptr);
    end
  endtask

  initial begin
    vec_t v;
    int   idx;
    logic [63:0] prev;

    dat[PORT_N]  = 64'h8000_0000_0000_00A0;
    dat[PORT_S]  = 64'h4000_0000_0000_00B0;
    dat[PORT_E]  = 64'h0000_0000_0000_00E0;
    dat[PORT_W]  = 64'h1000_0000_0000_00D0;
    dat[PORT_PE] = 64'h0800_0000_0000_00F0;
    for (int i = 0; i < 5; i++)
      bus.req_data[i*64 +: 64] = dat[i];
    bus.req = '0;
    bus.ro  = 1'b0;

    // idle after reset: phases alternate, nothing moves
    for (int i = 0; i < 10; i++)
      add(i[0] == 0, i[0] == 1, 5'b0, 1'b1,
          5'b0, 1'b0, 64'h0, 1'b0, 3'd0);

    // round robin, all five requesting, ro=1 throughout
    for (int k = 0; k < 10; k++) begin
      idx  = k % 5;
      prev = (k == 0) ? 64'h0 : dat[(k + 4) % 5];
      add(1, 0, 5'b11111, 1, 5'(1 << idx), 0, prev,
          0, 3'(idx));
      add(0, 1, 5'b11111, 1, 5'b0, 1, dat[idx],
          1, 3'((idx + 1) % 5));
    end

    // single E flit
    add(1, 0, 5'b00100, 0, 5'b00100, 0, dat[4], 0, 3'd0);
    add(0, 1, 5'b00000, 1, 5'b0, 1, dat[2], 1, 3'd3);
    add(1, 0, 5'b00000, 1, 5'b0, 0, dat[2], 0, 3'd3);

    // backpressure: W buffered, ro=0 for 3 external cycles
    add(1, 0, 5'b01000, 1, 5'b01000, 0, dat[2], 0, 3'd3);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 5'b00001, 0, 5'b0, 1, dat[3], 1, 3'd4);
      add(1, 0, 5'b00001, 1, 5'b0, 0, dat[3], 1, 3'd4);
    end
    add(0, 1, 5'b00001, 1, 5'b0, 1, dat[3], 1, 3'd4);
    add(1, 0, 5'b00001, 1, 5'b00001, 0, dat[3], 0, 3'd4);
    add(0, 1, 5'b00000, 1, 5'b0, 1, dat[0], 1, 3'd1);

    // illegal both-phases drains without a grant
    add(1, 0, 5'b00010, 1, 5'b00010, 0, dat[0], 0, 3'd1);
    add(1, 1, 5'b00010, 1, 5'b0, 1, dat[1], 1, 3'd2);
    add(0, 0, 5'b00010, 1, 5'b0, 0, dat[1], 0, 3'd2);
    add(1, 0, 5'b00010, 1, 5'b00010, 0, dat[1], 0, 3'd2);
    add(0, 0, 5'b00010, 1, 5'b0, 0, dat[1], 1, 3'd2);
    add(0, 1, 5'b00000, 1, 5'b0, 1, dat[1], 1, 3'd2);

    // reset held: everything zero
    #2;
    chk("in_reset", tbl[0]);
    #10 reset = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tbl[i]);
    end

    // async reset while a W flit is stalled
    @(posedge clk);
    #1;
    v = '{1, 0, 5'b01000, 0, 5'b01000, 0,
          dat[1], 0, 3'd2};
    drive(v);
    @(negedge clk);
    chk("stall_fill", v);
    @(posedge clk);
    #1;
    v = '{0, 1, 5'b11010, 0, 5'b0, 1,
          dat[3], 1, 3'd4};
    drive(v);
    @(negedge clk);
    chk("stall_hold", v);
    @(posedge clk);
    #1;
    v = '{1, 0, 5'b11010, 0, 5'b0, 0,
          64'h0, 0, 3'd0};
    drive(v);
    #1 reset = 1'b0;
    #1 chk("async_rst", v);
    #1 reset = 1'b1;
    v.gnt = 5'b00010;
    @(negedge clk);
    chk("post_rst_gnt", v);
    @(posedge clk);
    #1;
    v = '{0, 1, 5'b00000, 1, 5'b0, 1,
          dat[1], 1, 3'd2};
    drive(v);
    @(negedge clk);
    chk("post_rst_drain", v);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cardinal_output_arbiter.md
Name: cardinal_output_arbiter

Overview:
- Per-output-port, per-VC controller. It shares one router output channel (N, S, E, W or PE) among the five input buffers of the same VC block.
- During the VC's internal phase it grants one requesting input by round-robin and latches that flit into a 1-deep output buffer.
- During the VC's external phase it offers the buffered flit downstream with a send/ready (so/ro) handshake.
- There are two instances per output port per router, one per VC. Phase inputs are driven from the router's even/odd polarity.

Parameters:
- NUM_IN, 5, number of requesting input ports. Index order is N=0, S=1, E=2, W=3, PE=4.
- DW, 64, flit width in bits.
- PTR_W, 3, width of the round-robin pointer. Must satisfy 2^PTR_W >= NUM_IN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- phase_internal  in  1  high on this VC's internal (arbitration/latch) cycle.
- phase_external  in  1  high on this VC's external (link transfer) cycle.
- req  in  NUM_IN  req[i]=1 means input buffer i holds a flit routed to this output.
- req_data  in  NUM_IN*DW  flit of input i is at bits [i*DW +: DW].
- gnt  out  NUM_IN  one-hot combinational grant. Input i pops its buffer at the clock edge where gnt[i]=1.
- so  out  1  send-out to downstream.
- do  out  DW  data-out to downstream.
- ro  in  1  downstream ready.
- full  out  1  output buffer occupied, for status/debug.
- rr_ptr  out  PTR_W  current highest-priority index, for debug.

Behaviour:
- Reset (reset=0, asynchronous): full=0, buf_data=0, rr_ptr=0. Consequently so=0, do=0 and gnt=0 immediately, without waiting for a clock edge.
- Grant eligibility: grant_en = phase_internal & ~phase_external & ~full & (|req).
- Grant selection: gnt = one-hot of the first set req bit, searching circularly from rr_ptr upward and wrapping from NUM_IN-1 to 0. When grant_en=0, gnt=0. Grant is purely combinational from current req/rr_ptr/full/phases.
- On a clock edge with gnt[k]=1:
  - buf_data <= req_data[k].
  - full <= 1.
  - rr_ptr <= (k==NUM_IN-1) ? 0 : k+1.
  - Only one grant is issued per internal cycle.
- Drain:
  - so = full & phase_external.
  - do = buf_data at all times; do holds its last value when the buffer is empty.
  - On a clock edge with so & ro: full <= 0. rr_ptr and buf_data are unchanged.
- Latency: a flit granted in internal cycle t appears on so/do in cycle t+1 (the next external cycle) at the earliest. If ro=0, it stays stalled for whole external cycles. Minimum one flit per two clocks.
- Full buffer: no grant while full=1, even during phase_internal. req stays pending and rr_ptr is frozen.
- ro=0 during phase_external: so stays 1, do stays stable, buffer is retained until a later external cycle with ro=1.
- ro=1 while not in phase_external: ignored.
- Illegal phase_internal=phase_external=1:
  - Drain proceeds as normal.
  - No grant is issued, so no fill and drain occur in the same cycle.
- Both phases low: no activity; state holds.
- No requests during internal phase: gnt=0 and rr_ptr holds.
- req changes mid-cycle: gnt follows combinationally. Only the value present at the clock edge matters.
- Reset mid-operation: a flit in the buffer is discarded. The upstream input already popped it, so loss is accepted and the bench must not flag it. Both router VCs are reset together.
- Fairness: a continuously asserting requester is granted within NUM_IN grants.

Decomposition:
- Shared package: constants PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_PE=4, NUM_PORTS=5, FLIT_W=64, PTR_W=3. This package is also used by routing logic and the testbench.
- One sub-module, rr_arbiter. It is combinational: inputs req, ptr, en; output one-hot gnt. The parent owns the ptr register and its update.
- Remaining logic is inline in the parent: output buffer register, full flag, so/do.

Test Plan:
- Reset release, no traffic: req=0 with phases alternating for 10 cycles -> gnt=0, so=0, do=0, full=0, rr_ptr=0 throughout.
- Single flit: in an internal cycle, req=5'b00100 with E data=64'hE0 -> gnt=5'b00100, full=1, rr_ptr=3. Next cycle is external with ro=1 -> so=1, do=64'hE0, and full=0 after the edge.
- Round-robin fairness: req=5'b11111 held, ro=1, 10 phase pairs -> grant order N,S,E,W,PE,N,S,E,W,PE, and rr_ptr wraps 4->0.
- Backpressure: flit buffered, ro=0 for 3 external cycles -> so=1 and do stable each external cycle. gnt=0 in the interleaved internal cycles despite req=5'b00001. When ro=1, the flit drains and the next internal cycle grants N.
- Illegal both-phases: full=1, phase_internal=phase_external=1, ro=1, req=5'b00010 -> buffer drains, gnt=0, and the S flit is not latched that cycle.
- Async reset mid-stall: buffer full with ro=0, reset pulsed low between clock edges -> full, so and do go to 0 immediately and rr_ptr=0. After release, the first grant goes to the lowest-index requester.
